// File: rtl/tmds_encode.sv
// tmds_encode: TMDS 8b/10b character encoder with optional HDMI guard bands and TERC4 data islands.
module tmds_encode #(
    parameter string CHANNEL = "BLUE",
    parameter string MODE    = "DVI"
) (
    input  logic       clkin,
    input  logic       rstin,
    input  logic [7:0] vdin,
    input  logic [3:0] adin,
    input  logic       c0,
    input  logic       c1,
    input  logic       vde,
    input  logic       ade,
    output logic [9:0] dout
);
    localparam logic       HDMI    = (MODE == "HDMI");
    localparam logic       IS_BLUE = (CHANNEL == "BLUE");
    localparam logic [9:0] VID_GB  = (CHANNEL == "GREEN") ? 10'b0100110011 : 10'b1011001100;
    localparam logic [9:0] DI_GB   = 10'b0100110011;

    function automatic logic [3:0] popcount(input logic [7:0] x);
        popcount = '0;
        for (int i = 0; i < 8; i++) popcount = popcount + {3'b0, x[i]};
    endfunction

    function automatic logic [9:0] terc4(input logic [3:0] a);
        case (a)
            4'h0:    terc4 = 10'b1010011100;
            4'h1:    terc4 = 10'b1001100011;
            4'h2:    terc4 = 10'b1011100100;
            4'h3:    terc4 = 10'b1011100010;
            4'h4:    terc4 = 10'b0101110001;
            4'h5:    terc4 = 10'b0100011110;
            4'h6:    terc4 = 10'b0110001110;
            4'h7:    terc4 = 10'b0100111100;
            4'h8:    terc4 = 10'b1011001100;
            4'h9:    terc4 = 10'b0100111001;
            4'ha:    terc4 = 10'b0110011100;
            4'hb:    terc4 = 10'b1011000110;
            4'hc:    terc4 = 10'b1010001110;
            4'hd:    terc4 = 10'b1001110001;
            4'he:    terc4 = 10'b0101100011;
            default: terc4 = 10'b1011000011;
        endcase
    endfunction

    logic [7:0] d1;
    logic [3:0] n1d, ad1, ad2, n1q, n0q;
    logic       vde1, ade1, c0_1, c1_1, vde2, ade2, c0_2, c1_2, ade3, ade4;
    logic [8:0] q_m, qm2;
    logic [4:0] cnt, cnt_nxt, diff;
    logic [9:0] vid, ctl;
    logic       ade_in, dec1, dec2, dec3, vgb, dgb;

    assign ade_in = HDMI & ade;
    assign dec1   = n1d > 4'd4 || (n1d == 4'd4 && !d1[0]);

    always_comb begin
        q_m    = '0;
        q_m[0] = d1[0];
        for (int i = 1; i < 8; i++) q_m[i] = q_m[i-1] ^ d1[i] ^ dec1;
        q_m[8] = ~dec1;
    end

    // cnt is kept as raw 5-bit two's complement; bit 4 is its sign
    always_comb begin
        diff    = {1'b0, n1q} - {1'b0, n0q};
        dec2    = cnt == 5'd0 || n1q == n0q;
        dec3    = (!cnt[4] && cnt != 5'd0 && n1q > n0q) || (cnt[4] && n0q > n1q);
        vid     = dec2 ? {~qm2[8], qm2[8], qm2[8] ? qm2[7:0] : ~qm2[7:0]} :
                  dec3 ? {1'b1, qm2[8], ~qm2[7:0]} : {1'b0, qm2[8], qm2[7:0]};
        cnt_nxt = dec2 ? cnt + (qm2[8] ? diff : -diff) :
                  dec3 ? cnt + {3'b0, qm2[8], 1'b0} - diff : cnt + diff - {3'b0, ~qm2[8], 1'b0};
        ctl     = {c1_2, c0_2} == 2'b00 ? 10'b1101010100 :
                  {c1_2, c0_2} == 2'b01 ? 10'b0010101011 :
                  {c1_2, c0_2} == 2'b10 ? 10'b0101010100 : 10'b1010101011;
        // look ahead through stage 1 and the live inputs, look back through ade3/ade4
        vgb     = HDMI && !vde2 && (vde1 || vde);
        dgb     = HDMI && !ade2 && (ade1 || ade_in || ade3 || ade4);
    end

    always_ff @(posedge clkin) begin
        if (rstin) begin
            {d1, n1d, ad1, vde1, ade1, c0_1, c1_1} <= '0;
            {qm2, n1q, n0q, ad2, vde2, ade2, c0_2, c1_2, ade3, ade4} <= '0;
            cnt  <= '0;
            dout <= '0;
        end else begin
            d1   <= vdin;
            n1d  <= popcount(vdin);
            ad1  <= adin;
            vde1 <= vde;
            ade1 <= ade_in;
            c0_1 <= c0;
            c1_1 <= c1;
            qm2  <= q_m;
            n1q  <= popcount(q_m[7:0]);
            n0q  <= 4'd8 - popcount(q_m[7:0]);
            ad2  <= ad1;
            vde2 <= vde1;
            ade2 <= ade1;
            c0_2 <= c0_1;
            c1_2 <= c1_1;
            ade3 <= ade2;
            ade4 <= ade3;
            cnt  <= vde2 ? cnt_nxt : '0;
            dout <= vde2 ? vid : ade2 ? terc4(ad2) : vgb ? VID_GB :
                    dgb ? (IS_BLUE ? terc4({2'b11, c1_2, c0_2}) : DI_GB) : ctl;
        end
    end
endmodule

// File: tb/tb_tmds_encode.sv
// tb_tmds_encode: directed and randomized checks of tmds_encode against a behavioural TMDS model.
module tb_tmds_encode;
    logic       clkin = 1'b0;
    logic       rstin = 1'b1;
    logic [7:0] vdin  = '0;
    logic [3:0] adin  = '0;
    logic       c0 = 1'b0, c1 = 1'b0, vde = 1'b0, ade = 1'b0;
    logic [9:0] dout_d, dout_g, dout_b;
    int n_cmp = 0;
    int n_bad = 0;
    int m_cnt = 0;

    typedef struct packed {
        logic [7:0] vd;
        logic [3:0] ad;
        logic       c1;
        logic       c0;
        logic       vde;
        logic       ade;
    } smp_t;
    smp_t hist[$];

    logic [9:0] ctl_tab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    logic [9:0] terc_tab [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    localparam logic [9:0] GB_VG = 10'b0100110011;
    localparam logic [9:0] GB_VB = 10'b1011001100;
    localparam logic [9:0] GB_DG = 10'b0100110011;
    localparam logic [9:0] GB_DB = 10'b1001110001;

    always #5 clkin = ~clkin;

    tmds_encode #(.CHANNEL("BLUE"), .MODE("DVI")) u_dvi (
        .clkin(clkin), .rstin(rstin), .vdin(vdin), .adin(adin), .c0(c0), .c1(c1),
        .vde(vde), .ade(ade), .dout(dout_d));
    tmds_encode #(.CHANNEL("GREEN"), .MODE("HDMI")) u_green (
        .clkin(clkin), .rstin(rstin), .vdin(vdin), .adin(adin), .c0(c0), .c1(c1),
        .vde(vde), .ade(ade), .dout(dout_g));
    tmds_encode #(.CHANNEL("BLUE"), .MODE("HDMI")) u_blue (
        .clkin(clkin), .rstin(rstin), .vdin(vdin), .adin(adin), .c0(c0), .c1(c1),
        .vde(vde), .ade(ade), .dout(dout_b));

    task automatic drive(input logic [7:0] v, input logic [3:0] a, input logic h1, input logic h0,
                         input logic e, input logic ae);
        vdin = v; adin = a; c1 = h1; c0 = h0; vde = e; ade = ae;
    endtask

    // records the sample taken at the coming edge, then waits until just after it
    task automatic cyc();
        if (rstin) begin
            hist.delete();
            m_cnt = 0;
        end else hist.push_back(smp_t'({vdin, adin, c1, c0, vde, ade}));
        @(posedge clkin);
        #1;
    endtask

    function automatic smp_t at(input int j);
        if (j < 0) return '0;
        return hist[j];
    endfunction

    task automatic enc_video(input logic [7:0] d, output logic [9:0] v);
        int n1, ones, zeros, q8;
        logic use_xnor;
        logic [8:0] q;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(d[i]);
        use_xnor = n1 > 4 || (n1 == 4 && d[0] == 1'b0);
        q = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~use_xnor;
        q8 = int'(q[8]);
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(q[i]);
        zeros = 8 - ones;
        if (m_cnt == 0 || ones == zeros) begin
            v = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            m_cnt += q8 ? ones - zeros : zeros - ones;
        end else if ((m_cnt > 0 && ones > zeros) || (m_cnt < 0 && zeros > ones)) begin
            v = {1'b1, q[8], ~q[7:0]};
            m_cnt += 2 * q8 + zeros - ones;
        end else begin
            v = {1'b0, q[8], q[7:0]};
            m_cnt += ones - zeros - 2 * (1 - q8);
        end
    endtask

    task automatic model_char(input int k, output logic [9:0] ed, output logic [9:0] eg,
                              output logic [9:0] eb);
        smp_t s, p1, p2, f1, f2;
        logic [9:0] ctl, v;
        logic vgb, dgb;
        s = at(k); p1 = at(k - 1); p2 = at(k - 2); f1 = at(k + 1); f2 = at(k + 2);
        ctl = ctl_tab[{s.c1, s.c0}];
        vgb = (f1.vde && !s.vde) || (f2.vde && !f1.vde);
        dgb = (f1.ade && !s.ade) || (f2.ade && !f1.ade) || (p1.ade && !s.ade) || (p2.ade && !p1.ade);
        if (s.vde) begin
            enc_video(s.vd, v);
            ed = v; eg = v; eb = v;
        end else begin
            m_cnt = 0;
            ed = ctl;
            eg = s.ade ? terc_tab[s.ad] : vgb ? GB_VG : dgb ? GB_DG : ctl;
            eb = s.ade ? terc_tab[s.ad] : vgb ? GB_VB : dgb ? terc_tab[{2'b11, s.c1, s.c0}] : ctl;
        end
    endtask

    task automatic test_reset();
        rstin = 1'b1;
        drive(8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) cyc();
        rstin = 1'b0;
        drive(8'h5a, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) cyc();
        rstin = 1'b1;
        cyc();
        n_cmp++; if (dout_d !== 10'b0) begin n_bad++; $display("FAIL reset_dvi got %b want %b", dout_d, 10'b0); end
        n_cmp++; if (dout_g !== 10'b0) begin n_bad++; $display("FAIL reset_green got %b want %b", dout_g, 10'b0); end
        n_cmp++; if (dout_b !== 10'b0) begin n_bad++; $display("FAIL reset_blue got %b want %b", dout_b, 10'b0); end
        rstin = 1'b0;
        drive(8'h00, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) cyc();
        n_cmp++; if (dout_d !== ctl_tab[0]) begin n_bad++; $display("FAIL reset_latency got %b want %b", dout_d, ctl_tab[0]); end
        cyc();
        n_cmp++; if (dout_d !== ctl_tab[3]) begin n_bad++; $display("FAIL reset_first_char got %b want %b", dout_d, ctl_tab[3]); end
    endtask

    task automatic test_dvi_control();
        drive(8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc();
        n_cmp++; if (dout_d !== ctl_tab[0]) begin n_bad++; $display("FAIL ctl00_dvi got %b want %b", dout_d, ctl_tab[0]); end
        n_cmp++; if (dout_g !== ctl_tab[0]) begin n_bad++; $display("FAIL ctl00_green got %b want %b", dout_g, ctl_tab[0]); end
        drive(8'h00, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) cyc();
        n_cmp++; if (dout_d !== ctl_tab[0]) begin n_bad++; $display("FAIL ctl_latency got %b want %b", dout_d, ctl_tab[0]); end
        cyc();
        n_cmp++; if (dout_d !== ctl_tab[3]) begin n_bad++; $display("FAIL ctl11_dvi got %b want %b", dout_d, ctl_tab[3]); end
        n_cmp++; if (dout_g !== ctl_tab[3]) begin n_bad++; $display("FAIL ctl11_green got %b want %b", dout_g, ctl_tab[3]); end
    endtask

    task automatic test_dvi_video();
        logic [9:0] exp_v [4] = '{10'b0100000000, 10'b1111111111, 10'b0100000000, 10'b1101010100};
        for (int i = 0; i < 6; i++) begin
            drive(8'h00, 4'h0, 1'b0, 1'b0, i < 3, 1'b0);
            cyc();
            if (i >= 2) begin
                n_cmp++;
                if (dout_d !== exp_v[i-2]) begin n_bad++; $display("FAIL video_dvi[%0d] got %b want %b", i - 2, dout_d, exp_v[i-2]); end
            end
            if (i >= 2 && i < 5) begin
                n_cmp++;
                if (dout_g !== exp_v[i-2]) begin n_bad++; $display("FAIL video_green[%0d] got %b want %b", i - 2, dout_g, exp_v[i-2]); end
            end
        end
    endtask

    task automatic test_video_guard();
        logic [9:0] eg [4] = '{GB_VG, GB_VG, 10'b0100000000, 10'b1111111111};
        logic [9:0] eb [4] = '{GB_VB, GB_VB, 10'b0100000000, 10'b1111111111};
        logic [9:0] ed [4] = '{10'b1101010100, 10'b1101010100, 10'b0100000000, 10'b1111111111};
        drive(8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) cyc();
        n_cmp++; if (dout_g !== ctl_tab[0]) begin n_bad++; $display("FAIL pre_guard_green got %b want %b", dout_g, ctl_tab[0]); end
        for (int i = 0; i < 4; i++) begin
            drive(8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
            cyc();
            n_cmp++; if (dout_g !== eg[i]) begin n_bad++; $display("FAIL vguard_green[%0d] got %b want %b", i, dout_g, eg[i]); end
            n_cmp++; if (dout_b !== eb[i]) begin n_bad++; $display("FAIL vguard_blue[%0d] got %b want %b", i, dout_b, eb[i]); end
            n_cmp++; if (dout_d !== ed[i]) begin n_bad++; $display("FAIL vguard_dvi[%0d] got %b want %b", i, dout_d, ed[i]); end
        end
    endtask

    task automatic test_data_island();
        logic [3:0] ad_seq [4] = '{4'h0, 4'h1, 4'h2, 4'hf};
        logic [9:0] eg [9] = '{GB_DG, GB_DG, 10'b1010011100, 10'b1001100011, 10'b1011100100,
                               10'b1011000011, GB_DG, GB_DG, 10'b0010101011};
        logic [9:0] eb [9] = '{GB_DB, GB_DB, 10'b1010011100, 10'b1001100011, 10'b1011100100,
                               10'b1011000011, GB_DB, GB_DB, 10'b0010101011};
        drive(8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) cyc();
        n_cmp++; if (dout_d !== ctl_tab[1]) begin n_bad++; $display("FAIL ctl01_dvi got %b want %b", dout_d, ctl_tab[1]); end
        for (int i = 0; i < 9; i++) begin
            drive(8'h00, i < 4 ? ad_seq[i] : 4'h0, 1'b0, 1'b1, 1'b0, i < 4);
            cyc();
            n_cmp++; if (dout_g !== eg[i]) begin n_bad++; $display("FAIL island_green[%0d] got %b want %b", i, dout_g, eg[i]); end
            n_cmp++; if (dout_b !== eb[i]) begin n_bad++; $display("FAIL island_blue[%0d] got %b want %b", i, dout_b, eb[i]); end
            n_cmp++; if (dout_d !== ctl_tab[1]) begin n_bad++; $display("FAIL island_dvi[%0d] got %b want %b", i, dout_d, ctl_tab[1]); end
        end
    endtask

    task automatic test_random();
        int run, kind;
        logic [9:0] ed, eg, eb;
        run = 0;
        kind = 0;
        rstin = 1'b1;
        cyc();
        rstin = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if (run == 0) begin
                kind = int'($urandom_range(0, 2));
                run = int'($urandom_range(1, 10));
            end
            run--;
            drive(8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), kind == 1,
                  (kind == 2) ^ ($urandom_range(0, 15) == 0));
            rstin = ($urandom_range(0, 399) == 0);
            cyc();
            if (rstin) begin
                n_cmp++; if (dout_g !== 10'b0) begin n_bad++; $display("FAIL rand_reset t=%0d got %b want %b", t, dout_g, 10'b0); end
            end else if (hist.size() >= 3) begin
                model_char(hist.size() - 3, ed, eg, eb);
                n_cmp++; if (dout_d !== ed) begin n_bad++; $display("FAIL rand_dvi t=%0d got %b want %b", t, dout_d, ed); end
                n_cmp++; if (dout_g !== eg) begin n_bad++; $display("FAIL rand_green t=%0d got %b want %b", t, dout_g, eg); end
                n_cmp++; if (dout_b !== eb) begin n_bad++; $display("FAIL rand_blue t=%0d got %b want %b", t, dout_b, eb); end
            end
        end
        rstin = 1'b0;
    endtask

    initial begin
        test_reset();
        test_dvi_control();
        test_dvi_video();
        test_video_guard();
        test_data_island();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tmds_encode.md
TMDS_ENCODE -- requirements
Module: tmds_encode

Interface
REQ-001 SHALL have parameter CHANNEL, default "BLUE", selects guard-band codes; legal values "BLUE", "GREEN", "RED".
REQ-002 SHALL have parameter MODE, default "DVI"; "HDMI" enables guard bands and TERC4 data islands.
REQ-003 SHALL have port clkin, input, 1 bit: pixel clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rstin, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port vdin, input, 8 bits: video byte.
REQ-006 SHALL have port adin, input, 4 bits: auxiliary/audio nibble for TERC4.
REQ-007 SHALL have ports c0 and c1, inputs, 1 bit each: control bits (hsync/vsync on BLUE, CTL on GREEN/RED).
REQ-008 SHALL have port vde, input, 1 bit: video data enable.
REQ-009 SHALL have port ade, input, 1 bit: aux data enable; ignored when MODE="DVI".
REQ-010 SHALL have port dout, output, 10 bits, registered: TMDS character; bit 0 is transmitted first.

Function
REQ-011 SHALL sample all inputs at edge N and present the resulting character on dout after edge N+2, through a 3-register pipeline:
- stage 1 registers vdin and computes its popcount n1d;
- stage 2 registers q_m, n1q_m/n0q_m and pipelined vde/ade/c0/c1/adin;
- dout register.
REQ-012 SHALL compute the stage-1 decision:
- decision1 = (n1d>4) or (n1d==4 and d[0]==0);
- q_m[0]=d[0]; q_m[i] = q_m[i-1] XNOR d[i] if decision1, else XOR (i=1..7);
- q_m[8] = not decision1.
REQ-013 SHALL keep a 5-bit two's-complement disparity counter cnt, and compute:
- decision2 = (cnt==0) or (n1q_m==n0q_m);
- decision3 = (cnt>0 and n1q_m>n0q_m) or (cnt<0 and n0q_m>n1q_m).
REQ-014 When video is active and decision2 is true, SHALL output dout = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}, and update cnt += q_m[8] ? (n1-n0) : (n0-n1).
REQ-015 When video is active, decision2 is false and decision3 is true, SHALL output dout = {1, q_m[8], ~q_m[7:0]}, and update cnt += 2*q_m[8] + n0 - n1.
REQ-016 When video is active and neither decision2 nor decision3 holds, SHALL output dout = {0, q_m[8], q_m[7:0]}, and update cnt += n1 - n0 - 2*(~q_m[8]).
REQ-017 When vde=0 and no HDMI period applies, SHALL output the control code for {c1,c0}: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
REQ-018 SHALL clear cnt to 0 on every non-video character.
REQ-019 In HDMI mode with ade=1 and vde=0, SHALL output TERC4(adin) per this table (value→code):
- 0→1010011100, 1→1001100011, 2→1011100100, 3→1011100010;
- 4→0101110001, 5→0100011110, 6→0110001110, 7→0100111100;
- 8→1011001100, 9→0100111001, A→0110011100, B→1011000110;
- C→1010001110, D→1001110001, E→0101100011, F→1011000011.
REQ-020 In HDMI mode, SHALL replace the two characters immediately preceding a vde 0→1 transition with the video guard band, using pipeline look-ahead: BLUE=1011001100, GREEN=0100110011, RED=1011001100.
REQ-021 In HDMI mode, SHALL emit the data-island guard band on the two characters preceding an ade 0→1 transition and on the two characters following an ade 1→0 transition:
- GREEN and RED = 0100110011;
- BLUE = TERC4({1,1,c1,c0}).
REQ-022 SHALL apply this output priority: video data > TERC4 data > video guard band > data-island guard band > control code.
REQ-023 In DVI mode, SHALL emit no guard bands and no TERC4 codes.

Reset
REQ-024 While rstin=1 at a rising edge, SHALL set dout=0000000000, clear cnt and all pipeline registers (enables read as 0), and clear guard-band history.
REQ-025 Reset asserted mid-frame SHALL take effect at the next edge; after release, the first valid character SHALL appear 3 edges after the first sampled input.

Verification
REQ-026 Reset: rstin=1 for one edge during video → dout=0000000000 and cnt=0 after that edge.
REQ-027 DVI control: vde=0, {c1,c0}=00 held → dout=1101010100; {c1,c0}=11 → 1010101011, two edges after input change.
REQ-028 DVI video: after control (cnt=0), vdin=0x00 for three pixels → 0100000000, 1111111111, 0100000000, with cnt going -8, +2, -6.
REQ-029 HDMI GREEN: vde rises at sample N with vdin=0x00 → characters for samples N-2 and N-1 are 0100110011, then 0100000000.
REQ-030 HDMI GREEN data island: ade=1 for 4 samples with adin=0,1,2,F → sequence 0100110011 ×2, then 1010011100, 1001100011, 1011100100, 1011000011, then 0100110011 ×2, then control.
REQ-031 HDMI BLUE data-island guard band with c1=0, c0=1 → 1001110001 (TERC4 value D).
